// File: rtl/pyc_cdc_pkg.sv
// pyc_cdc_pkg
//   Shared definitions for the 2-phase (toggle) request/ack CDC handshake.
//   The source (pyc_cdc_hs_tx) and the matching receiver both import this
//   package so that the state encodings agree on both sides.
//   Contents:
//     pyc_cdc_state_e  1-bit handshake state (IDLE / WAIT)
//     PYC_CDC_MIN_STAGES  smallest legal synchronizer depth

package pyc_cdc_pkg;

  typedef enum logic {
    PYC_CDC_ST_IDLE = 1'b0,
    PYC_CDC_ST_WAIT = 1'b1
  } pyc_cdc_state_e;

  localparam int PYC_CDC_MIN_STAGES = 1;

endpackage

// File: rtl/pyc_cdc_sync_arn.sv
// pyc_cdc_sync_arn
//   Multi-flop level synchronizer with asynchronous active-low reset.
//   A change on d sampled at edge T appears on q after edge T+STAGES-1.
//   Ports:
//     clk    in   1      destination clock
//     rst_n  in   1      asynchronous active-low reset, clears the chain
//     d      in   WIDTH  asynchronous input level
//     q      out  WIDTH  synchronized level (last flop of the chain)

module pyc_cdc_sync_arn
  import pyc_cdc_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // A zero-depth chain has no meaning; stop elaboration instead of building it.
  if (STAGES < PYC_CDC_MIN_STAGES) begin : g_bad_stages
    $fatal(1, "pyc_cdc_sync_arn: STAGES must be >= 1");
  end

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        chain[i] <= '0;
      end
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pyc_cdc_hs_tx.sv
// pyc_cdc_hs_tx
//   Source side of a 2-phase (toggle) request/ack CDC handshake.
//   A word accepted via in_valid/in_ready is registered onto data_o and
//   announced by toggling req_o. The block then waits until the synchronized
//   ack level equals req_o, pulses done and becomes ready again.
//   Ports:
//     clk       in   1      local clock
//     rst_n     in   1      asynchronous active-low reset
//     in_valid  in   1      producer has a word
//     in_ready  out  1      word can be accepted this cycle
//     in_data   in   WIDTH  payload, sampled on the accept edge
//     data_o    out  WIDTH  registered payload, stable while waiting
//     req_o     out  1      request level, toggles once per transfer
//     ack_i     in   1      ack level from the destination (asynchronous)
//     done      out  1      one-cycle pulse when a transfer is acknowledged
//     err       out  1      sticky: ack toggled with nothing outstanding

module pyc_cdc_hs_tx
  import pyc_cdc_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] data_o,
  output logic             req_o,
  input  logic             ack_i,
  output logic             done,
  output logic             err
);

  pyc_cdc_state_e   state_q, state_d;
  logic             req_q, req_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ack_s;
  logic             accept;

  pyc_cdc_sync_arn #(
    .WIDTH (1),
    .STAGES(STAGES)
  ) u_ack_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (ack_i),
    .q    (ack_s)
  );

  // Gated by rst_n so the producer never sees ready while reset is held.
  assign in_ready = rst_n & (state_q == PYC_CDC_ST_IDLE);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PYC_CDC_ST_IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      PYC_CDC_ST_IDLE: begin
        // In IDLE the ack level must already match req; any difference is a
        // toggle the destination made without a request outstanding.
        if (ack_s != req_q) begin
          err_d = 1'b1;
        end
        if (accept) begin
          data_d  = in_data;
          req_d   = ~req_q;
          state_d = PYC_CDC_ST_WAIT;
        end
      end
      PYC_CDC_ST_WAIT: begin
        if (ack_s == req_q) begin
          state_d = PYC_CDC_ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = PYC_CDC_ST_IDLE;
      end
    endcase
  end

  // CDC outputs come straight from flops, with no logic in between.
  assign req_o  = req_q;
  assign data_o = data_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule
